// File: rtl/irq_controller_pkg.sv
// Shared constants, bus command encodings, register offsets and FSM states
// for the irq_controller block.
package irq_controller_pkg;

    localparam int unsigned DATA_SIZE = 32;
    localparam int unsigned CMD_SIZE  = 3;
    localparam int unsigned PADD_SIZE = 24;
    localparam int unsigned NUM_IRQ   = 8;

    localparam logic [23:0] IRQ_BASE  = 24'h080030;

    localparam logic [2:0]  CMD_WR    = 3'b010;
    localparam logic [2:0]  CMD_RD    = 3'b001;

    localparam int unsigned OFF_PEND  = 0;
    localparam int unsigned OFF_MASK  = 1;
    localparam int unsigned OFF_MODE  = 2;
    localparam int unsigned OFF_VECT  = 3;
    localparam int unsigned OFF_EOI   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_SVC  = 2'b10
    } irq_state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports the lowest-index set request bit.
module irq_prio_enc
    import irq_controller_pkg::*;
#(
    parameter int unsigned num_irq = NUM_IRQ
) (
    input  logic [num_irq-1:0] i_req,
    output logic [2:0]         o_idx,
    output logic               o_valid
);

    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        for (int unsigned i = 0; i < num_irq; i++) begin
            if (i_req[i] && !o_valid) begin
                o_idx   = i[2:0];
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: pending/mask/mode registers, fixed
// priority, ack + EOI handshake. Optional input synchronizer: IRQ_CTRL_SYNC_EN.
module irq_controller
    import irq_controller_pkg::*;
#(
    parameter int unsigned          data_size = DATA_SIZE,
    parameter int unsigned          cmd_size  = CMD_SIZE,
    parameter int unsigned          padd_size = PADD_SIZE,
    parameter int unsigned          num_irq   = NUM_IRQ,
    parameter logic [padd_size-1:0] irq_base  = padd_size'(IRQ_BASE)
) (
    input  logic                 clk0,
    input  logic                 reset,
    input  logic [data_size-1:0] irq_host_datain,
    input  logic [cmd_size-1:0]  irq_cmd,
    input  logic [padd_size-1:0] irq_addr,
    input  logic [num_irq-1:0]   irq_src,
    input  logic                 irq_ack,
    output logic [data_size-1:0] irq_host_dataout,
    output logic                 cpu_irq,
    output logic [2:0]           irq_vector
);

    logic [num_irq-1:0]   w_src;
    logic [num_irq-1:0]   r_src_prev;
    logic [num_irq-1:0]   r_pend;
    logic [num_irq-1:0]   r_mask;
    logic [num_irq-1:0]   r_mode;
    logic [num_irq-1:0]   w_active;
    logic [num_irq-1:0]   w_clr;
    logic [num_irq-1:0]   w_pend_nxt;
    logic [padd_size-1:0] w_off;
    logic                 w_wr;
    logic                 w_rd;
    logic                 w_mapped;
    logic                 w_eoi;
    logic [data_size-1:0] w_rdata;
    logic [data_size-1:0] r_dataout;
    logic [2:0]           w_prio_idx;
    logic                 w_prio_valid;
    logic [2:0]           r_vector;
    logic                 r_cpu_irq;
    logic                 w_latch;
    logic                 w_ack_fire;
    irq_state_t           r_state;
    irq_state_t           w_state_nxt;
    logic                 w_unused;

`ifdef IRQ_CTRL_SYNC_EN
    logic [num_irq-1:0] r_sync1;
    logic [num_irq-1:0] r_sync2;

    always_ff @(posedge clk0 or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= irq_src;
            r_sync2 <= r_sync1;
        end
    end

    assign w_src = r_sync2;
`else
    assign w_src = irq_src;
`endif

    assign w_unused = ^irq_host_datain[data_size-1:num_irq];

    assign w_off    = irq_addr - irq_base;
    assign w_wr     = (irq_cmd == cmd_size'(CMD_WR));
    assign w_rd     = (irq_cmd == cmd_size'(CMD_RD));
    assign w_mapped = (w_off <= padd_size'(OFF_EOI));
    assign w_eoi    = w_wr && (w_off == padd_size'(OFF_EOI));
    assign w_active = r_pend & r_mask;

    irq_prio_enc #(
        .num_irq (num_irq)
    ) u_prio (
        .i_req   (w_active),
        .o_idx   (w_prio_idx),
        .o_valid (w_prio_valid)
    );

    // Host W1C and the ack-time clear share one mask; a coincident rising edge wins.
    always_comb begin
        w_clr = '0;
        if (w_wr && (w_off == padd_size'(OFF_PEND))) begin
            w_clr = irq_host_datain[num_irq-1:0];
        end
        for (int unsigned i = 0; i < num_irq; i++) begin
            if (w_ack_fire && (r_vector == i[2:0])) begin
                w_clr[i] = 1'b1;
            end
        end
        w_pend_nxt = (r_mode & ((r_pend & ~w_clr) | (w_src & ~r_src_prev)))
                   | (~r_mode & w_src);
    end

    always_comb begin
        w_rdata = '0;
        if (w_off == padd_size'(OFF_PEND)) begin
            w_rdata[num_irq-1:0] = r_pend;
        end else if (w_off == padd_size'(OFF_MASK)) begin
            w_rdata[num_irq-1:0] = r_mask;
        end else if (w_off == padd_size'(OFF_MODE)) begin
            w_rdata[num_irq-1:0] = r_mode;
        end else if (w_off == padd_size'(OFF_VECT)) begin
            w_rdata[data_size-1] = (r_state == ST_SVC);
            w_rdata[data_size-2] = (r_state == ST_REQ);
            w_rdata[2:0]         = r_vector;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_ack_fire  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_prio_valid) begin
                    w_state_nxt = ST_REQ;
                    w_latch     = 1'b1;
                end
            end
            ST_REQ: begin
                if (!w_prio_valid) begin
                    w_state_nxt = ST_IDLE;
                end else if (irq_ack) begin
                    w_state_nxt = ST_SVC;
                    w_ack_fire  = 1'b1;
                end
            end
            ST_SVC: begin
                if (w_eoi) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk0 or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk0 or negedge reset) begin
        if (!reset) begin
            r_src_prev <= '0;
            r_pend     <= '0;
            r_mask     <= '0;
            r_mode     <= '0;
            r_dataout  <= '0;
            r_vector   <= '0;
            r_cpu_irq  <= 1'b0;
        end else begin
            r_src_prev <= w_src;
            r_pend     <= w_pend_nxt;
            r_cpu_irq  <= (w_state_nxt == ST_REQ);
            if (w_latch) begin
                r_vector <= w_prio_idx;
            end
            if (w_wr && (w_off == padd_size'(OFF_MASK))) begin
                r_mask <= irq_host_datain[num_irq-1:0];
            end
            if (w_wr && (w_off == padd_size'(OFF_MODE))) begin
                r_mode <= irq_host_datain[num_irq-1:0];
            end
            if (w_rd && w_mapped) begin
                r_dataout <= w_rdata;
            end
        end
    end

    assign irq_host_dataout = r_dataout;
    assign cpu_irq          = r_cpu_irq;
    assign irq_vector       = r_vector;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller with a cycle-level reference model and
// per-cycle output comparison.
module tb_irq_controller;

    localparam logic [23:0] BASE = 24'h080030;

    logic        clk0 = 1'b0;
    logic        reset;
    logic [31:0] datain;
    logic [2:0]  cmd;
    logic [23:0] addr;
    logic [7:0]  src;
    logic        ack;
    logic [31:0] dataout;
    logic        cpu_irq;
    logic [2:0]  vector;

    int checks = 0;
    int errors = 0;

    logic [7:0]  m_pend, m_mask, m_mode, m_prev;
    logic        m_req, m_svc;
    logic [2:0]  m_vec;
    logic [31:0] m_dout;
    logic [31:0] rdv;

    always #5 clk0 = ~clk0;

    irq_controller dut (
        .clk0             (clk0),
        .reset            (reset),
        .irq_host_datain  (datain),
        .irq_cmd          (cmd),
        .irq_addr         (addr),
        .irq_src          (src),
        .irq_ack          (ack),
        .irq_host_dataout (dataout),
        .cpu_irq          (cpu_irq),
        .irq_vector       (vector)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] lowest(input logic [7:0] a);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (a[i]) r = 3'(i);
        end
        return r;
    endfunction

    task automatic model_reset();
        m_pend = 8'h00; m_mask = 8'h00; m_mode = 8'h00; m_prev = 8'h00;
        m_req  = 1'b0;  m_svc  = 1'b0;  m_vec  = 3'd0;  m_dout = 32'h0;
    endtask

    // One clock of the register map and request/service handshake.
    task automatic model_step();
        logic [7:0]  act, clr, np;
        logic [23:0] off;
        logic        is_wr, is_rd;
        act   = m_pend & m_mask;
        off   = addr - BASE;
        is_wr = (cmd == 3'b010);
        is_rd = (cmd == 3'b001);
        if (is_rd && off < 24'd5) begin
            case (off)
                24'd0:   m_dout = {24'h0, m_pend};
                24'd1:   m_dout = {24'h0, m_mask};
                24'd2:   m_dout = {24'h0, m_mode};
                24'd3:   m_dout = {m_svc, m_req, 27'h0, m_vec};
                default: m_dout = 32'h0;
            endcase
        end
        clr = (is_wr && off == 24'd0) ? datain[7:0] : 8'h00;
        if (m_req) begin
            if (act == 8'h00) begin
                m_req = 1'b0;
            end else if (ack) begin
                m_req = 1'b0;
                m_svc = 1'b1;
                clr[m_vec] = 1'b1;
            end
        end else if (m_svc) begin
            if (is_wr && off == 24'd4) m_svc = 1'b0;
        end else if (act != 8'h00) begin
            m_req = 1'b1;
            m_vec = lowest(act);
        end
        for (int i = 0; i < 8; i++) begin
            np[i] = m_mode[i] ? ((src[i] & ~m_prev[i]) | (m_pend[i] & ~clr[i])) : src[i];
        end
        m_pend = np;
        m_prev = src;
        if (is_wr && off == 24'd1) m_mask = datain[7:0];
        if (is_wr && off == 24'd2) m_mode = datain[7:0];
    endtask

    task automatic tick();
        @(posedge clk0);
        #1;
    endtask

    task automatic wr(input int unsigned off, input logic [31:0] d);
        addr   = BASE + 24'(off);
        datain = d;
        cmd    = 3'b010;
        tick();
        cmd    = 3'b000;
    endtask

    task automatic rd(input int unsigned off, output logic [31:0] v);
        addr = BASE + 24'(off);
        cmd  = 3'b001;
        tick();
        cmd  = 3'b000;
        v    = dataout;
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cmd = 3'b000; addr = 24'h0; datain = 32'h0; src = 8'h00; ack = 1'b0;
        model_reset();
        fork
            forever begin
                @(posedge clk0 or negedge reset);
                if (!reset) model_reset();
                else        model_step();
            end
            forever begin
                @(negedge clk0);
                chk("cyc_cpu_irq", 32'(cpu_irq), 32'(m_req));
                chk("cyc_vector",  32'(vector),  32'(m_vec));
                chk("cyc_dataout", dataout,      m_dout);
            end
        join_none

        #2 reset = 1'b0;
        tick(); tick();
        chk("rst_cpu_irq", 32'(cpu_irq), 32'h0);
        chk("rst_vector",  32'(vector),  32'h0);
        chk("rst_dataout", dataout,      32'h0);
        reset = 1'b1;
        tick();
        rd(1, rdv); chk("rst_mask", rdv, 32'h0);

        // Timer on bit 0, edge mode.
        wr(2, 32'h29);
        wr(1, 32'h01);
        src = 8'h01; tick(); src = 8'h00;
        chk("t1_n1_cpu", 32'(cpu_irq), 32'h0);
        tick();
        chk("t1_n2_cpu", 32'(cpu_irq), 32'h1);
        chk("t1_n2_vec", 32'(vector),  32'h0);
        pulse_ack();
        chk("t1_ack_cpu", 32'(cpu_irq), 32'h0);
        rd(0, rdv); chk("t1_pend", rdv, 32'h0);
        rd(3, rdv); chk("t1_vect_svc", rdv, 32'h8000_0000);
        wr(4, 32'h0);
        rd(3, rdv); chk("t1_vect_idle", rdv, 32'h0);

        // Bits 3 and 5 together: 3 first, then 5 after EOI.
        wr(1, 32'h28);
        src = 8'h28; tick(); src = 8'h00; tick();
        chk("t2_cpu", 32'(cpu_irq), 32'h1);
        chk("t2_vec3", 32'(vector), 32'h3);
        pulse_ack();
        wr(4, 32'h0);
        chk("t2_eoi1_cpu", 32'(cpu_irq), 32'h0);
        tick();
        chk("t2_eoi2_cpu", 32'(cpu_irq), 32'h1);
        chk("t2_vec5", 32'(vector), 32'h5);
        pulse_ack();
        wr(4, 32'h0);
        rd(0, rdv); chk("t2_pend", rdv, 32'h0);

        // Level source on bit 2 held high.
        wr(1, 32'h04);
        src = 8'h04; tick(); tick();
        chk("t3_cpu", 32'(cpu_irq), 32'h1);
        chk("t3_vec", 32'(vector), 32'h2);
        pulse_ack();
        chk("t3_ack_cpu", 32'(cpu_irq), 32'h0);
        wr(0, 32'h04);
        rd(0, rdv); chk("t3_w1c_ignored", rdv, 32'h04);
        wr(4, 32'h0);
        chk("t3_eoi1_cpu", 32'(cpu_irq), 32'h0);
        tick();
        chk("t3_eoi2_cpu", 32'(cpu_irq), 32'h1);
        chk("t3_eoi2_vec", 32'(vector), 32'h2);
        src = 8'h00; tick(); tick(); tick();
        chk("t3_drop_cpu", 32'(cpu_irq), 32'h0);

        // Edge and W1C on the same bit in the same cycle.
        wr(1, 32'h0);
        src = 8'h08; addr = BASE; datain = 32'h08; cmd = 3'b010;
        tick();
        cmd = 3'b000; src = 8'h00;
        rd(0, rdv); chk("t4_set_wins", rdv, 32'h08);
        wr(0, 32'h08);
        rd(0, rdv); chk("t4_w1c", rdv, 32'h0);
        rd(2, rdv); chk("t4_mode", rdv, 32'h29);
        wr(6, 32'hFF);
        rd(7, rdv); chk("t4_unmapped_rd", rdv, 32'h29);
        rd(1, rdv); chk("t4_unmapped_wr", rdv, 32'h0);

        // Mask cleared while the request is presented.
        wr(1, 32'h20);
        src = 8'h20; tick(); src = 8'h00; tick();
        chk("t5_cpu", 32'(cpu_irq), 32'h1);
        chk("t5_vec", 32'(vector), 32'h5);
        wr(1, 32'h0);
        chk("t5_still_req", 32'(cpu_irq), 32'h1);
        tick();
        chk("t5_dropped", 32'(cpu_irq), 32'h0);
        pulse_ack();
        rd(3, rdv); chk("t5_vect", rdv, 32'h0000_0005);
        rd(0, rdv); chk("t5_pend_kept", rdv, 32'h20);
        wr(0, 32'h20);

        // Reset while in service with every source pending.
        wr(2, 32'hFF);
        wr(1, 32'hFF);
        src = 8'hFF; tick(); src = 8'h00; tick();
        chk("t6_cpu", 32'(cpu_irq), 32'h1);
        pulse_ack();
        src = 8'h01; tick(); src = 8'h00;
        rd(0, rdv); chk("t6_pend_ff", rdv, 32'hFF);
        rd(3, rdv); chk("t6_vect_svc", rdv, 32'h8000_0000);
        reset = 1'b0;
        #1;
        chk("t6_rst_cpu", 32'(cpu_irq), 32'h0);
        chk("t6_rst_vec", 32'(vector), 32'h0);
        chk("t6_rst_dout", dataout, 32'h0);
        tick();
        reset = 1'b1;
        rd(1, rdv); chk("t6_mask", rdv, 32'h0);
        rd(0, rdv); chk("t6_pend", rdv, 32'h0);
        rd(2, rdv); chk("t6_mode", rdv, 32'h0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
